fc_argmax: RTL and testbench

- Classification stage directly downstream of the fully-connected layer.
- Captures the ten signed class scores (prob_0..prob_9) on the rising edge of fc_done.
- Scans them sequentially, one comparison per cycle, and reports the winning class index and its score with a one-cycle valid pulse.
- Feeds the display/UART result path; the design's final stage.

---
 rtl/fc_pkg.sv | 19 +
 rtl/fc_argmax_if.sv | 24 ++
 rtl/argmax_cmp_stage.sv | 38 +++
 rtl/fc_argmax.sv | 138 +++++++++++++
 tb/tb_fc_argmax.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// Shared constants and types for the fc_argmax classification stage.
package fc_pkg;

  localparam int NUM_CLASS  = 10;
  localparam int PROB_WIDTH = 113;
  localparam int IDX_WIDTH  = 4;

  typedef logic signed [PROB_WIDTH-1:0] prob_t;
  typedef logic [IDX_WIDTH-1:0]         idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scanState_t;

  localparam prob_t PROB_MOST_NEG = {1'b1, {(PROB_WIDTH-1){1'b0}}};

endpackage

// File: rtl/fc_argmax_if.sv
// Score-in / result-out bundle between the FC layer, fc_argmax and the display/UART path.
interface fc_argmax_if;
  import fc_pkg::*;

  logic                i_fcDone;
  prob_t               i_prob [NUM_CLASS];
  idx_t                o_classIdx;
  prob_t               o_classScore;
  logic [PROB_WIDTH:0] o_classMargin;
  logic                o_classValid;
  logic                o_busy;
  logic                o_overrun;

  modport master (
    output i_fcDone, i_prob,
    input  o_classIdx, o_classScore, o_classMargin, o_classValid, o_busy, o_overrun
  );

  modport slave (
    input  i_fcDone, i_prob,
    output o_classIdx, o_classScore, o_classMargin, o_classValid, o_busy, o_overrun
  );

endinterface

// File: rtl/argmax_cmp_stage.sv
// One signed compare step of the argmax scan; strictly-greater replace keeps the lower index on ties.
// Runner-up tracking is present only when ARGMAX_MARGIN_EN is defined.
module argmax_cmp_stage
  import fc_pkg::*;
(
  input  prob_t i_cand,
  input  idx_t  i_candIdx,
  input  prob_t i_best,
  input  idx_t  i_bestIdx,
`ifdef ARGMAX_MARGIN_EN
  input  prob_t i_second,
  output prob_t o_nextSecond,
`endif
  output prob_t o_nextBest,
  output idx_t  o_nextBestIdx
);

  always_comb begin
    o_nextBest    = i_best;
    o_nextBestIdx = i_bestIdx;
`ifdef ARGMAX_MARGIN_EN
    o_nextSecond  = i_second;
`endif
    if (i_cand > i_best) begin
`ifdef ARGMAX_MARGIN_EN
      o_nextSecond  = i_best;
`endif
      o_nextBest    = i_cand;
      o_nextBestIdx = i_candIdx;
    end
`ifdef ARGMAX_MARGIN_EN
    else if (i_cand > i_second) begin
      o_nextSecond = i_cand;
    end
`endif
  end

endmodule

// File: rtl/fc_argmax.sv
// Sequential argmax over the ten FC class scores, one compare per cycle, with a one-cycle result pulse.
// Define ARGMAX_MARGIN_EN to report best-minus-runner-up on o_classMargin; otherwise it reads 0.
module fc_argmax
  import fc_pkg::*;
(
  input logic        clk,
  input logic        rst,
  fc_argmax_if.slave bus
);

  scanState_t r_state;
  scanState_t w_nextState;
  logic       r_fcDoneQ;
  logic       w_start;

  prob_t r_array [NUM_CLASS];
  prob_t r_best;
  idx_t  r_bestIdx;
  idx_t  r_cnt;
  prob_t w_nextBest;
  idx_t  w_nextBestIdx;

  idx_t  r_classIdx;
  prob_t r_classScore;
  logic  r_classValid;
  logic  r_busy;
  logic  r_overrun;

  assign w_start = bus.i_fcDone & ~r_fcDoneQ;

`ifdef ARGMAX_MARGIN_EN
  prob_t               r_second;
  prob_t               w_nextSecond;
  logic [PROB_WIDTH:0] r_classMargin;

  argmax_cmp_stage u_cmp (
    .i_cand        (r_array[r_cnt]),
    .i_candIdx     (r_cnt),
    .i_best        (r_best),
    .i_bestIdx     (r_bestIdx),
    .i_second      (r_second),
    .o_nextSecond  (w_nextSecond),
    .o_nextBest    (w_nextBest),
    .o_nextBestIdx (w_nextBestIdx)
  );

  assign bus.o_classMargin = r_classMargin;
`else
  argmax_cmp_stage u_cmp (
    .i_cand        (r_array[r_cnt]),
    .i_candIdx     (r_cnt),
    .i_best        (r_best),
    .i_bestIdx     (r_bestIdx),
    .o_nextBest    (w_nextBest),
    .o_nextBestIdx (w_nextBestIdx)
  );

  assign bus.o_classMargin = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_start) w_nextState = SCAN;
      SCAN:    if (r_cnt == IDX_WIDTH'(NUM_CLASS-1)) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // A start edge seen in SCAN or DONE is dropped but flagged; only IDLE accepts a capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fcDoneQ    <= 1'b0;
      for (int k = 0; k < NUM_CLASS; k++) r_array[k] <= '0;
      r_best       <= '0;
      r_bestIdx    <= '0;
      r_cnt        <= '0;
      r_classIdx   <= '0;
      r_classScore <= '0;
      r_classValid <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
      r_second      <= PROB_MOST_NEG;
      r_classMargin <= '0;
`endif
    end else begin
      r_fcDoneQ    <= bus.i_fcDone;
      r_classValid <= 1'b0;
      if (w_start && (r_state != IDLE)) r_overrun <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_array   <= bus.i_prob;
            r_best    <= bus.i_prob[0];
            r_bestIdx <= '0;
            r_cnt     <= IDX_WIDTH'(1);
            r_busy    <= 1'b1;
`ifdef ARGMAX_MARGIN_EN
            r_second  <= PROB_MOST_NEG;
`endif
          end
        end
        SCAN: begin
          r_best    <= w_nextBest;
          r_bestIdx <= w_nextBestIdx;
          r_cnt     <= r_cnt + 1'b1;
`ifdef ARGMAX_MARGIN_EN
          r_second  <= w_nextSecond;
`endif
        end
        DONE: begin
          r_classIdx   <= r_bestIdx;
          r_classScore <= r_best;
          r_classValid <= 1'b1;
          r_busy       <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
          r_classMargin <= {r_best[PROB_WIDTH-1], r_best} - {r_second[PROB_WIDTH-1], r_second};
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.o_classIdx   = r_classIdx;
  assign bus.o_classScore = r_classScore;
  assign bus.o_classValid = r_classValid;
  assign bus.o_busy       = r_busy;
  assign bus.o_overrun    = r_overrun;

endmodule

// File: tb/tb_fc_argmax.sv
// Directed self-checking bench for fc_argmax; margin expectations follow ARGMAX_MARGIN_EN.
module tb_fc_argmax;
  import fc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checkCount = 0;
  int   failCount  = 0;
  int   validCount = 0;

  fc_argmax_if bus();

  fc_argmax dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.o_classValid) validCount++;

  task automatic checkOutput(input string tag, input logic signed [PROB_WIDTH:0] observed,
                             input logic signed [PROB_WIDTH:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input prob_t vals [NUM_CLASS]);
    @(negedge clk);
    bus.i_prob   = vals;
    bus.i_fcDone = 1'b1;
  endtask

  task automatic releaseStart();
    @(negedge clk);
    bus.i_fcDone = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitForValid(output int cycles);
    cycles = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.o_classValid) begin
        cycles = n;
        break;
      end
    end
    if (cycles < 0) checkOutput("validTimeout", 0, 1);
  endtask

  task automatic checkMargin(input string tag, input int expectedWhenEnabled);
`ifdef ARGMAX_MARGIN_EN
    checkOutput(tag, bus.o_classMargin, expectedWhenEnabled);
`else
    checkOutput(tag, bus.o_classMargin, 0);
    if (expectedWhenEnabled < 0) $display("[TB] negative margin expectation in %s", tag);
`endif
  endtask

  initial begin
    prob_t vals [NUM_CLASS];
    int    lat;
    int    vc0;

    bus.i_fcDone = 1'b0;
    for (int k = 0; k < NUM_CLASS; k++) bus.i_prob[k] = '0;

    repeat (3) @(negedge clk);
    checkOutput("rstIdx",     bus.o_classIdx,    0);
    checkOutput("rstScore",   bus.o_classScore,  0);
    checkOutput("rstMargin",  bus.o_classMargin, 0);
    checkOutput("rstValid",   bus.o_classValid,  0);
    checkOutput("rstBusy",    bus.o_busy,        0);
    checkOutput("rstOverrun", bus.o_overrun,     0);
    rst = 1'b0;
    @(negedge clk);

    // Ascending scores: winner is the last entry.
    for (int k = 0; k < NUM_CLASS; k++) vals[k] = prob_t'(k * 100);
    applyStimulus(vals);
    waitForValid(lat);
    checkOutput("t1Latency", lat, 11);
    checkOutput("t1Idx",     bus.o_classIdx,   9);
    checkOutput("t1Score",   bus.o_classScore, 900);
    checkMargin("t1Margin", 100);
    checkOutput("t1BusyLow", bus.o_busy, 0);
    @(negedge clk);
    checkOutput("t1PulseOne", bus.o_classValid, 0);
    checkOutput("t1IdxHold",  bus.o_classIdx,   9);
    releaseStart();

    // All negative: signed compare must pick -5.
    for (int k = 0; k < NUM_CLASS; k++) vals[k] = prob_t'(-1000);
    vals[3] = prob_t'(-5);
    applyStimulus(vals);
    waitForValid(lat);
    checkOutput("t2Idx",   bus.o_classIdx,   3);
    checkOutput("t2Score", bus.o_classScore, -5);
    checkMargin("t2Margin", 995);
    releaseStart();

    // Tie between entries 2 and 7 keeps the lower index.
    for (int k = 0; k < NUM_CLASS; k++) vals[k] = '0;
    vals[2] = prob_t'(500);
    vals[7] = prob_t'(500);
    applyStimulus(vals);
    waitForValid(lat);
    checkOutput("t3Idx",   bus.o_classIdx,   2);
    checkOutput("t3Score", bus.o_classScore, 500);
    checkMargin("t3Margin", 0);
    releaseStart();

    // Second start edge during SCAN with new scores: dropped, overrun set.
    vc0 = validCount;
    for (int k = 0; k < NUM_CLASS; k++) vals[k] = prob_t'((9 - k) * 10);
    applyStimulus(vals);
    @(negedge clk);
    bus.i_fcDone = 1'b0;
    for (int k = 0; k < NUM_CLASS; k++) bus.i_prob[k] = '0;
    bus.i_prob[5] = prob_t'(10000);
    @(negedge clk);
    @(negedge clk);
    bus.i_fcDone = 1'b1;
    waitForValid(lat);
    checkOutput("t4Latency", lat, 8);
    checkOutput("t4Idx",     bus.o_classIdx,   0);
    checkOutput("t4Score",   bus.o_classScore, 90);
    checkMargin("t4Margin", 10);
    checkOutput("t4Overrun", bus.o_overrun, 1);
    repeat (15) @(negedge clk);
    checkOutput("t4OnePulse", validCount - vc0, 1);
    releaseStart();

    // Reset while cnt=5 aborts the scan and clears every output.
    for (int k = 0; k < NUM_CLASS; k++) vals[k] = prob_t'(k * 100);
    applyStimulus(vals);
    repeat (5) @(negedge clk);
    checkOutput("t5BusyMid", bus.o_busy, 1);
    vc0 = validCount;
    rst = 1'b1;
    #1;
    checkOutput("t5Busy",    bus.o_busy,        0);
    checkOutput("t5Idx",     bus.o_classIdx,    0);
    checkOutput("t5Score",   bus.o_classScore,  0);
    checkOutput("t5Margin",  bus.o_classMargin, 0);
    checkOutput("t5Overrun", bus.o_overrun,     0);
    bus.i_fcDone = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("t5NoValid", validCount - vc0, 0);
    for (int k = 0; k < NUM_CLASS; k++) vals[k] = prob_t'(-1000);
    vals[3] = prob_t'(-5);
    applyStimulus(vals);
    waitForValid(lat);
    checkOutput("t5FreshIdx",   bus.o_classIdx,   3);
    checkOutput("t5FreshScore", bus.o_classScore, -5);
    releaseStart();

    // Level held for 50 cycles with scores changing mid-scan: one scan on the captured data.
    vc0 = validCount;
    for (int k = 0; k < NUM_CLASS; k++) vals[k] = prob_t'(1);
    vals[6] = prob_t'(777);
    applyStimulus(vals);
    repeat (2) @(negedge clk);
    for (int k = 0; k < NUM_CLASS; k++) bus.i_prob[k] = '0;
    bus.i_prob[1] = prob_t'(5000);
    waitForValid(lat);
    checkOutput("t6Latency", lat, 9);
    checkOutput("t6Idx",     bus.o_classIdx,   6);
    checkOutput("t6Score",   bus.o_classScore, 777);
    checkMargin("t6Margin", 776);
    repeat (39) @(negedge clk);
    checkOutput("t6OnePulse", validCount - vc0, 1);
    checkOutput("t6Overrun",  bus.o_overrun,    0);
    releaseStart();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
